// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the ID-stage hazard/stall controller.
package hazard_stall_controller_pkg;

  localparam int unsigned RA_W_DEFAULT = 5;
  localparam int unsigned REG_ZERO     = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // Number of stall cycles a detected hazard requires.
  typedef logic [1:0] need_t;
  localparam need_t NEED_NONE = 2'd0;
  localparam need_t NEED_ONE  = 2'd1;
  localparam need_t NEED_TWO  = 2'd2;

endpackage

// File: rtl/hazard_stall_controller_need.sv
// Combinational hazard classifier: stall cycles needed by the ID instruction.
module hazard_need_decode
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned RA_W         = RA_W_DEFAULT,
  parameter bit          BRANCH_IN_ID = 1'b1,
  parameter bit          ZERO_REG_EN  = 1'b1
) (
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_branch,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_memread,
  output need_t           need,
  output logic            is_branch_event
);

  logic match_ex;
  logic match_mem;
  logic branch_rules;

  // Register 0 is hard-wired, so it never carries a real dependency.
  always_comb begin
    match_ex  = ((ex_rd == id_rs) && id_uses_rs) || ((ex_rd == id_rt) && id_uses_rt);
    match_mem = ((mem_rd == id_rs) && id_uses_rs) || ((mem_rd == id_rt) && id_uses_rt);
    if (ZERO_REG_EN) begin
      match_ex  = match_ex  && (ex_rd  != RA_W'(REG_ZERO));
      match_mem = match_mem && (mem_rd != RA_W'(REG_ZERO));
    end
  end

  assign branch_rules = BRANCH_IN_ID && id_branch;

  always_comb begin
    need = NEED_NONE;
    if (ex_memread && ex_regwrite && match_ex) begin
      need = branch_rules ? NEED_TWO : NEED_ONE;
    end else if (branch_rules && ex_regwrite && match_ex) begin
      need = NEED_ONE;
    end else if (branch_rules && mem_memread && match_mem) begin
      need = NEED_ONE;
    end
  end

  assign is_branch_event = id_branch;

endmodule

// File: rtl/hazard_stall_controller.sv
// ID-stage hazard/stall controller: stall sequencing, pipeline enables/flushes
// and saturating performance counters.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned RA_W         = RA_W_DEFAULT,
  parameter int unsigned PERF_W       = 32,
  parameter bit          BRANCH_IN_ID = 1'b1,
  parameter bit          ZERO_REG_EN  = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [RA_W-1:0]   IDRs,
  input  logic [RA_W-1:0]   IDRt,
  input  logic              IDUsesRs,
  input  logic              IDUsesRt,
  input  logic              IDBranch,
  input  logic              BranchTaken,
  input  logic [RA_W-1:0]   EXRd,
  input  logic              EXRegWrite,
  input  logic              EXMemRead,
  input  logic [RA_W-1:0]   MEMRd,
  input  logic              MEMMemRead,
  output logic              PCWriteEnable,
  output logic              IFIDWriteEnable,
  output logic              IDEXFlush,
  output logic              IFIDFlush,
  output logic              Stalling,
  output logic [PERF_W-1:0] StallCycles,
  output logic [PERF_W-1:0] LoadUseEvents,
  output logic [PERF_W-1:0] BranchStallEvents
);

  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  need_t need;
  logic  is_branch_event;
  logic  stall_c;
  logic  entry_c;

  hazard_need_decode #(
    .RA_W        (RA_W),
    .BRANCH_IN_ID(BRANCH_IN_ID),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_need (
    .id_rs          (IDRs),
    .id_rt          (IDRt),
    .id_uses_rs     (IDUsesRs),
    .id_uses_rt     (IDUsesRt),
    .id_branch      (IDBranch),
    .ex_rd          (EXRd),
    .ex_regwrite    (EXRegWrite),
    .ex_memread     (EXMemRead),
    .mem_rd         (MEMRd),
    .mem_memread    (MEMMemRead),
    .need           (need),
    .is_branch_event(is_branch_event)
  );

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt holds the stall cycles still owed after the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (need != NEED_NONE) begin
          cnt_d   = need - 2'd1;
          state_d = (need == NEED_TWO) ? STALL : IDLE;
        end
      end
      STALL: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Stall is Mealy in IDLE so a hazard costs no detection latency.
  assign entry_c = (state_q == IDLE) && (need != NEED_NONE);
  assign stall_c = (state_q == STALL) || entry_c;

  always_comb begin
    PCWriteEnable   = 1'b1;
    IFIDWriteEnable = 1'b1;
    IDEXFlush       = 1'b0;
    IFIDFlush       = 1'b0;
    Stalling        = 1'b0;
    if (!Reset) begin
      PCWriteEnable   = 1'b0;
      IFIDWriteEnable = 1'b0;
      IDEXFlush       = 1'b1;
      IFIDFlush       = 1'b1;
    end else if (stall_c) begin
      PCWriteEnable   = 1'b0;
      IFIDWriteEnable = 1'b0;
      IDEXFlush       = 1'b1;
      Stalling        = 1'b1;
    end else begin
      IFIDFlush = IDBranch && BranchTaken;
    end
  end

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
  endfunction

  // Event counters only see the IDLE->stall entry, not the continuation cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      StallCycles       <= '0;
      LoadUseEvents     <= '0;
      BranchStallEvents <= '0;
    end else begin
      if (stall_c) begin
        StallCycles <= sat_inc(StallCycles);
      end
      if (entry_c && is_branch_event) begin
        BranchStallEvents <= sat_inc(BranchStallEvents);
      end
      if (entry_c && !is_branch_event) begin
        LoadUseEvents <= sat_inc(LoadUseEvents);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: table of single-cycle vectors
// plus hand sequences for multi-cycle stalls, reset abort and saturation.
module tb_hazard_stall_controller;

  localparam int unsigned RA_W = 5;

  logic            Clock;
  logic            Reset;
  logic [RA_W-1:0] IDRs, IDRt, EXRd, MEMRd;
  logic            IDUsesRs, IDUsesRt, IDBranch, BranchTaken;
  logic            EXRegWrite, EXMemRead, MEMMemRead;

  logic        PCWriteEnable, IFIDWriteEnable, IDEXFlush, IFIDFlush, Stalling;
  logic [31:0] StallCycles, LoadUseEvents, BranchStallEvents;

  logic        s_pcwe, s_ifidwe, s_idexfl, s_ifidfl, s_stalling;
  logic [1:0]  s_stall_cycles, s_load_use, s_branch_ev;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_stall_controller dut (
    .Clock(Clock), .Reset(Reset),
    .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDBranch(IDBranch), .BranchTaken(BranchTaken),
    .EXRd(EXRd), .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead),
    .MEMRd(MEMRd), .MEMMemRead(MEMMemRead),
    .PCWriteEnable(PCWriteEnable), .IFIDWriteEnable(IFIDWriteEnable),
    .IDEXFlush(IDEXFlush), .IFIDFlush(IFIDFlush), .Stalling(Stalling),
    .StallCycles(StallCycles), .LoadUseEvents(LoadUseEvents),
    .BranchStallEvents(BranchStallEvents)
  );

  hazard_stall_controller #(.PERF_W(2)) dut_sat (
    .Clock(Clock), .Reset(Reset),
    .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
    .IDBranch(IDBranch), .BranchTaken(BranchTaken),
    .EXRd(EXRd), .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead),
    .MEMRd(MEMRd), .MEMMemRead(MEMMemRead),
    .PCWriteEnable(s_pcwe), .IFIDWriteEnable(s_ifidwe),
    .IDEXFlush(s_idexfl), .IFIDFlush(s_ifidfl), .Stalling(s_stalling),
    .StallCycles(s_stall_cycles), .LoadUseEvents(s_load_use),
    .BranchStallEvents(s_branch_ev)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {PCWriteEnable, IFIDWriteEnable, IDEXFlush, IFIDFlush, Stalling}
  localparam logic [4:0] O_STALL = 5'b00101;
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_FLUSH = 5'b11010;
  localparam logic [4:0] O_RESET = 5'b00110;

  typedef struct {
    string           name;
    logic [RA_W-1:0] rs;
    logic            urs;
    logic [RA_W-1:0] rt;
    logic            urt;
    logic            br;
    logic            taken;
    logic [RA_W-1:0] exrd;
    logic            exrw;
    logic            exmr;
    logic [RA_W-1:0] memrd;
    logic            memmr;
    logic [4:0]      exp;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string name, int rs, bit urs, int rt, bit urt, bit br, bit taken,
                              int exrd, bit exrw, bit exmr, int memrd, bit memmr,
                              logic [4:0] exp);
    vec_t v;
    v.name = name; v.rs = RA_W'(rs); v.urs = urs; v.rt = RA_W'(rt); v.urt = urt;
    v.br = br; v.taken = taken; v.exrd = RA_W'(exrd); v.exrw = exrw; v.exmr = exmr;
    v.memrd = RA_W'(memrd); v.memmr = memmr; v.exp = exp;
    return v;
  endfunction

  function automatic logic [4:0] outs();
    return {PCWriteEnable, IFIDWriteEnable, IDEXFlush, IFIDFlush, Stalling};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    IDRs = v.rs; IDUsesRs = v.urs; IDRt = v.rt; IDUsesRt = v.urt;
    IDBranch = v.br; BranchTaken = v.taken;
    EXRd = v.exrd; EXRegWrite = v.exrw; EXMemRead = v.exmr;
    MEMRd = v.memrd; MEMMemRead = v.memmr;
  endtask

  task automatic clear_inputs();
    apply(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN));
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_counters(input string tag, input int sc, input int lu, input int be);
    check({tag, ".StallCycles"}, StallCycles, 32'(sc));
    check({tag, ".LoadUseEvents"}, LoadUseEvents, 32'(lu));
    check({tag, ".BranchStallEvents"}, BranchStallEvents, 32'(be));
  endtask

  initial begin
    vecs[0]  = mk("loaduse_rs",      8, 1, 0, 0, 0, 0,  8, 1, 1,  0, 0, O_STALL);
    vecs[1]  = mk("loaduse_rt",      0, 0, 9, 1, 0, 0,  9, 1, 1,  0, 0, O_STALL);
    vecs[2]  = mk("zero_reg_load",   0, 1, 0, 1, 0, 0,  0, 1, 1,  0, 0, O_RUN);
    vecs[3]  = mk("unused_rs_load",  8, 0, 3, 1, 0, 0,  8, 1, 1,  0, 0, O_RUN);
    vecs[4]  = mk("alu_nonbranch",   8, 1, 0, 0, 0, 0,  8, 1, 0,  0, 0, O_RUN);
    vecs[5]  = mk("alu_branch_rt",   1, 1, 9, 1, 1, 1,  9, 1, 0,  0, 0, O_STALL);
    vecs[6]  = mk("memload_branch", 10, 1, 2, 1, 1, 0,  4, 1, 0, 10, 1, O_STALL);
    vecs[7]  = mk("memload_nonbr",  10, 1, 2, 1, 0, 0,  4, 1, 0, 10, 1, O_RUN);
    vecs[8]  = mk("branch_taken",    5, 1, 6, 1, 1, 1,  7, 1, 1,  3, 1, O_FLUSH);
    vecs[9]  = mk("branch_nottaken", 5, 1, 6, 1, 1, 0,  7, 1, 1,  3, 1, O_RUN);
    vecs[10] = mk("taken_nonbranch", 5, 1, 6, 1, 0, 1,  0, 0, 0,  0, 0, O_RUN);
    vecs[11] = mk("load_no_regwr",   8, 1, 0, 0, 0, 0,  8, 0, 1,  0, 0, O_RUN);
    vecs[12] = mk("branch_no_regwr", 8, 1, 0, 0, 1, 1,  8, 0, 0,  8, 0, O_FLUSH);

    // Reset: combinational override and cleared counters.
    Reset = 1'b0;
    apply(vecs[0]);
    cyc(); cyc();
    check("reset.outputs", 32'(outs()), 32'(O_RESET));
    check_counters("reset", 0, 0, 0);
    clear_inputs();
    Reset = 1'b1;
    #1;
    check("post_reset.outputs", 32'(outs()), 32'(O_RUN));

    // Single-cycle vectors, each starting and ending in IDLE.
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      #2;
      check(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      cyc();
    end
    clear_inputs();
    #1;
    check("table.idle_after", 32'(outs()), 32'(O_RUN));
    check_counters("table", 4, 2, 2);

    // T2: load in EX feeding a branch in ID -> two stall cycles.
    apply(mk("t2", 8, 1, 0, 0, 1, 1, 8, 1, 1, 0, 0, O_STALL));
    #2;
    check("t2.cycle1", 32'(outs()), 32'(O_STALL));
    cyc();
    apply(mk("t2b", 8, 1, 0, 0, 1, 1, 0, 0, 0, 8, 1, O_STALL));
    #2;
    check("t2.cycle2", 32'(outs()), 32'(O_STALL));
    cyc();
    check_counters("t2.mid", 6, 2, 3);
    apply(mk("t2c", 8, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, O_FLUSH));
    #2;
    check("t2.resolved", 32'(outs()), 32'(O_FLUSH));
    cyc();
    check_counters("t2.end", 6, 2, 3);

    // T3: ALU result in EX feeding a branch -> one stall, then taken flush.
    apply(mk("t3", 1, 1, 9, 1, 1, 1, 9, 1, 0, 0, 0, O_STALL));
    #2;
    check("t3.stall", 32'(outs()), 32'(O_STALL));
    cyc();
    apply(mk("t3b", 1, 1, 9, 1, 1, 1, 0, 0, 0, 9, 0, O_FLUSH));
    #2;
    check("t3.taken", 32'(outs()), 32'(O_FLUSH));
    cyc();
    check_counters("t3", 7, 2, 4);

    // T5: reset asserted in the first cycle of a two-cycle stall.
    apply(mk("t5", 8, 1, 0, 0, 1, 0, 8, 1, 1, 0, 0, O_STALL));
    #2;
    check("t5.entry", 32'(outs()), 32'(O_STALL));
    Reset = 1'b0;
    #1;
    check("t5.reset_override", 32'(outs()), 32'(O_RESET));
    cyc();
    Reset = 1'b1;
    clear_inputs();
    #1;
    check("t5.no_residual", 32'(outs()), 32'(O_RUN));
    check_counters("t5", 0, 0, 0);
    cyc();
    check("t5.still_idle", 32'(outs()), 32'(O_RUN));

    // T6: five load-use stalls; PERF_W=2 counters saturate at 3.
    for (int i = 0; i < 5; i++) begin
      apply(mk("t6", 8, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0, O_STALL));
      #2;
      check("t6.stall", 32'(outs()), 32'(O_STALL));
      cyc();
      clear_inputs();
      cyc();
    end
    check("t6.sat.StallCycles", 32'(s_stall_cycles), 32'd3);
    check("t6.sat.LoadUseEvents", 32'(s_load_use), 32'd3);
    check("t6.sat.BranchStallEvents", 32'(s_branch_ev), 32'd0);
    check("t6.sat.Stalling", 32'(s_stalling), 32'd0);
    check_counters("t6.wide", 5, 5, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
